// File: rtl/input_cmd_scheduler.sv
// ----------------------------------------------------------------------------
// input_cmd_scheduler
//
// Collects one-cycle action pulses from the per-button DAS instances and offers
// them one at a time to the game engine over a valid/ready command port. Each
// channel is disarmed (action_valid low) while its command is pending, so a
// button cannot re-fire before the engine has taken its previous command.
// After a hard drop is accepted, every channel is disarmed for LOCKOUT_CYCLES
// cycles and anything still pending is discarded.
//
// Parameters:
//   NUM_ACTIONS    number of action channels
//   HARD_DROP_IDX  channel whose handshake starts the lockout window
//   LOCKOUT_CYCLES lockout length in clk cycles (0 disables lockout)
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-high reset
//   action_pulse  one-cycle pulse per channel (DAS action_out)
//   action_valid  arm signal per channel (DAS action_valid), combinational
//   game_active   high while a piece is in play
//   cmd_valid     a command is offered to the engine
//   cmd_id        channel index of the offered command
//   cmd_ready     engine accepts the offered command
//   cmd_dropped   one-cycle flag: a pulse arrived on a disarmed channel
//
// Build option:
//   INPUT_SCHED_RR_EN  when defined, round-robin arbitration with a rotating
//                      priority pointer; otherwise fixed lowest-index priority.
// ----------------------------------------------------------------------------
module input_cmd_scheduler #(
   parameter int NUM_ACTIONS    = 7,
   parameter int HARD_DROP_IDX  = 5,
   parameter int LOCKOUT_CYCLES = 500_000
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_ACTIONS-1:0]         action_pulse,
   output logic [NUM_ACTIONS-1:0]         action_valid,
   input  logic                           game_active,
   output logic                           cmd_valid,
   output logic [$clog2(NUM_ACTIONS)-1:0] cmd_id,
   input  logic                           cmd_ready,
   output logic                           cmd_dropped
);

   localparam int ID_W = $clog2(NUM_ACTIONS);

   // A zero-length lockout would give a zero-width counter; keep one bit so
   // the register is always legal even though it is then never used.
   localparam int CNT_W = (LOCKOUT_CYCLES > 0) ? $clog2(LOCKOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST =
      (LOCKOUT_CYCLES > 0) ? CNT_W'(LOCKOUT_CYCLES - 1) : '0;
   localparam logic [ID_W-1:0] HARD_DROP_ID = ID_W'(HARD_DROP_IDX);
   localparam logic [ID_W-1:0] LAST_ID      = ID_W'(NUM_ACTIONS - 1);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      LOCKOUT
   } state_t;

   state_t                 state;
   state_t                 state_nx;
   logic [NUM_ACTIONS-1:0] pending;
   logic [NUM_ACTIONS-1:0] pending_nx;
   logic [NUM_ACTIONS-1:0] set_mask;
   logic [NUM_ACTIONS-1:0] clr_mask;
   logic [CNT_W-1:0]       lock_cnt;
   logic [CNT_W-1:0]       lock_cnt_nx;
   logic [ID_W-1:0]        cmd_id_nx;
   logic                   dropped_nx;
   logic                   handshake;
   logic                   lock_entry;
   logic [ID_W-1:0]        winner;
   logic                   winner_found;

   // ---------------------------------------------------------------------------
   // Outputs derived directly from registers (and game_active for the arms).
   // ---------------------------------------------------------------------------
   assign cmd_valid    = (state == ISSUE);
   assign handshake    = cmd_valid && cmd_ready;
   assign action_valid = {NUM_ACTIONS{game_active && (state != LOCKOUT)}} & ~pending;

   // ---------------------------------------------------------------------------
   // Arbiter
   // ---------------------------------------------------------------------------
`ifdef INPUT_SCHED_RR_EN
   logic [ID_W-1:0] rr_ptr;
   int              rr_idx;

   // Search starts at the pointer and wraps; the first pending hit wins.
   always_comb begin
      // NOTE: every variable written here gets a default first, so no path
      // leaves one unassigned and no latch is inferred.
      winner       = '0;
      winner_found = 1'b0;
      rr_idx       = 0;
      for (int k = 0; k < NUM_ACTIONS; k++) begin
         rr_idx = int'(rr_ptr) + k;
         if (rr_idx >= NUM_ACTIONS) begin
            rr_idx = rr_idx - NUM_ACTIONS;
         end
         if (!winner_found && pending[rr_idx]) begin
            winner       = ID_W'(rr_idx);
            winner_found = 1'b1;
         end
      end
   end

   // The channel just served becomes the lowest priority.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (handshake) begin
         rr_ptr <= (cmd_id == LAST_ID) ? '0 : cmd_id + 1'b1;
      end
   end
`else
   // Scan from the top down so the lowest pending index is the last writer.
   always_comb begin
      winner       = '0;
      winner_found = 1'b0;
      for (int k = NUM_ACTIONS - 1; k >= 0; k--) begin
         if (pending[k]) begin
            winner       = ID_W'(k);
            winner_found = 1'b1;
         end
      end
   end
`endif

   // ---------------------------------------------------------------------------
   // Next-state, pending bookkeeping and lockout counter
   // ---------------------------------------------------------------------------
   always_comb begin
      state_nx    = state;
      cmd_id_nx   = cmd_id;
      lock_cnt_nx = '0;
      clr_mask    = '0;
      lock_entry  = 1'b0;

      // A pulse is only accepted on an armed channel.
      set_mask   = action_pulse & action_valid;
      dropped_nx = |(action_pulse & ~action_valid);

      unique case (state)
         IDLE: begin
            // No new arbitration once the piece is gone: pending is about
            // to be flushed and must not produce a command.
            if (winner_found && game_active) begin
               cmd_id_nx = winner;
               state_nx  = ISSUE;
            end
         end

         ISSUE: begin
            // cmd_id stays put until the engine takes it, even with the
            // game inactive; an offered command is never retracted.
            if (handshake) begin
               clr_mask = {{(NUM_ACTIONS-1){1'b0}}, 1'b1} << cmd_id;
               if ((cmd_id == HARD_DROP_ID) && (LOCKOUT_CYCLES > 0)) begin
                  state_nx   = LOCKOUT;
                  lock_entry = 1'b1;
               end else begin
                  state_nx = IDLE;
               end
            end
         end

         LOCKOUT: begin
            // Counts 0..LOCKOUT_CYCLES-1, so the window is exactly
            // LOCKOUT_CYCLES cycles and the counter never wraps.
            if (lock_cnt == CNT_LAST) begin
               state_nx = IDLE;
            end else begin
               lock_cnt_nx = lock_cnt + 1'b1;
            end
         end

         default: begin
            state_nx = IDLE;
         end
      endcase

      // A set beats a handshake clear on the same bit. Entering lockout or
      // losing the piece discards everything, including a same-cycle set.
      pending_nx = (pending & ~clr_mask) | set_mask;
      if (!game_active || lock_entry) begin
         pending_nx = '0;
      end
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         pending     <= '0;
         cmd_id      <= '0;
         lock_cnt    <= '0;
         cmd_dropped <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // values from before this edge, independent of statement order.
         state       <= state_nx;
         pending     <= pending_nx;
         cmd_id      <= cmd_id_nx;
         lock_cnt    <= lock_cnt_nx;
         cmd_dropped <= dropped_nx;
      end
   end

endmodule

// File: tb/tb_input_cmd_scheduler.sv
// ----------------------------------------------------------------------------
// tb_input_cmd_scheduler
//
// Directed bench for input_cmd_scheduler (LOCKOUT_CYCLES = 8). Expected command
// ids are queued when pulses are driven and popped whenever a handshake is
// seen. Inputs change 1 time unit after the rising edge; outputs are sampled
// on the falling edge.
// ----------------------------------------------------------------------------
module tb_input_cmd_scheduler;

   localparam int NA = 7;
   localparam int LC = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [NA-1:0] action_pulse;
   logic [NA-1:0] action_valid;
   logic          game_active;
   logic          cmd_valid;
   logic [2:0]    cmd_id;
   logic          cmd_ready;
   logic          cmd_dropped;

   int checks   = 0;
   int failures = 0;
   int grants   = 0;
   int exp_q[$];

   always #5 clk = ~clk;

   input_cmd_scheduler #(
      .NUM_ACTIONS   (NA),
      .HARD_DROP_IDX (5),
      .LOCKOUT_CYCLES(LC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .action_pulse(action_pulse),
      .action_valid(action_valid),
      .game_active (game_active),
      .cmd_valid   (cmd_valid),
      .cmd_id      (cmd_id),
      .cmd_ready   (cmd_ready),
      .cmd_dropped (cmd_dropped)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Falling-edge sample point; every handshake is scored here.
   task automatic mid();
      @(negedge clk);
      if (cmd_valid && cmd_ready) begin
         grants++;
         if (exp_q.size() == 0) begin
            check("unexpected_cmd", {29'd0, cmd_id}, 32'hffff_ffff);
         end else begin
            check("sb_cmd_id", {29'd0, cmd_id}, exp_q.pop_front());
         end
      end
   endtask

   // Drive point: just after the rising edge.
   task automatic edge_();
      @(posedge clk);
      #1;
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         mid();
         edge_();
      end
   endtask

   int cnt [3];
   int base_grants;

   initial begin
      rst          = 1'b1;
      game_active  = 1'b0;
      cmd_ready    = 1'b1;
      action_pulse = '0;

      // ---------------- reset values ----------------
      #3;
      check("rst_av_inactive", action_valid, 7'h00);
      check("rst_cmd_valid", cmd_valid, 1'b0);
      check("rst_cmd_id", cmd_id, 3'd0);
      check("rst_cmd_dropped", cmd_dropped, 1'b0);
      game_active = 1'b1;
      #1;
      check("rst_av_active", action_valid, 7'h7f);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      tick(2);

      // ---------------- single command, latency ----------------
      action_pulse = 7'b000_0100;
      exp_q.push_back(2);
      mid(); check("t1_valid_t0", cmd_valid, 1'b0); edge_();
      action_pulse = '0;
      mid(); check("t1_valid_t1", cmd_valid, 1'b0);
             check("t1_av2_t1", action_valid[2], 1'b0); edge_();
      mid(); check("t1_valid_t2", cmd_valid, 1'b1);
             check("t1_id_t2", cmd_id, 3'd2);
             check("t1_av2_t2", action_valid[2], 1'b0); edge_();
      mid(); check("t1_valid_t3", cmd_valid, 1'b0);
             check("t1_av2_t3", action_valid[2], 1'b1); edge_();

      // ---------------- backpressure, two pending ----------------
      cmd_ready    = 1'b0;
      action_pulse = 7'b001_0010;
      exp_q.push_back(1);
      exp_q.push_back(4);
      tick(1);
      action_pulse = '0;
      tick(1);
      for (int k = 0; k < 6; k++) begin
         if (k == 5) cmd_ready = 1'b1;
         mid();
         check("t2_hold_valid", cmd_valid, 1'b1);
         check("t2_hold_id", cmd_id, 3'd1);
         edge_();
      end
      mid(); check("t2_gap_valid", cmd_valid, 1'b0); edge_();
      mid(); check("t2_second_valid", cmd_valid, 1'b1);
             check("t2_second_id", cmd_id, 3'd4); edge_();
      tick(1);

      // ---------------- hard drop lockout ----------------
      action_pulse = 7'b010_0001;
      exp_q.push_back(0);
      exp_q.push_back(5);
      tick(1);
      action_pulse = '0;
      tick(1);
      mid(); check("t3_id0", cmd_id, 3'd0); edge_();
      mid(); check("t3_gap", cmd_valid, 1'b0); edge_();
      mid(); check("t3_id5", cmd_id, 3'd5); edge_();
      for (int k = 0; k < LC; k++) begin
         action_pulse = (k == 1) ? 7'b000_1000 : 7'b000_0000;
         mid();
         check("t3_lock_av", action_valid, 7'h00);
         check("t3_lock_valid", cmd_valid, 1'b0);
         if (k == 2) check("t3_dropped", cmd_dropped, 1'b1);
         if (k == 3) check("t3_dropped_clr", cmd_dropped, 1'b0);
         edge_();
      end
      mid(); check("t3_exit_av", action_valid, 7'h7f);
             check("t3_exit_valid", cmd_valid, 1'b0); edge_();
      mid(); check("t3_no_cmd", cmd_valid, 1'b0); edge_();

      // ---------------- game_active falls mid-issue ----------------
      cmd_ready    = 1'b0;
      action_pulse = 7'b000_1001;
      exp_q.push_back(0);
      tick(1);
      action_pulse = '0;
      tick(1);
      mid(); check("t4_issue_id", cmd_id, 3'd0); edge_();
      game_active = 1'b0;
      mid(); check("t4_held_valid", cmd_valid, 1'b1);
             check("t4_av_off", action_valid, 7'h00); edge_();
      cmd_ready = 1'b1;
      tick(1);
      game_active = 1'b1;
      mid(); check("t4_after_valid", cmd_valid, 1'b0);
             check("t4_av_rearm", action_valid, 7'h7f); edge_();
      mid(); check("t4_no_cmd_a", cmd_valid, 1'b0); edge_();
      mid(); check("t4_no_cmd_b", cmd_valid, 1'b0); edge_();

      // ---------------- reset mid-lockout ----------------
      action_pulse = 7'b010_0000;
      exp_q.push_back(5);
      tick(1);
      action_pulse = '0;
      tick(2);
      mid(); check("t5_in_lock", action_valid, 7'h00); edge_();
      rst = 1'b1;
      #1;
      check("t5_lock_rst_av", action_valid, 7'h7f);
      check("t5_lock_rst_valid", cmd_valid, 1'b0);
      check("t5_lock_rst_id", cmd_id, 3'd0);
      check("t5_lock_rst_drop", cmd_dropped, 1'b0);
      edge_();
      rst = 1'b0;
      tick(1);

      // ---------------- reset mid-issue ----------------
      cmd_ready    = 1'b0;
      action_pulse = 7'b001_0000;
      tick(1);
      action_pulse = '0;
      tick(1);
      mid(); check("t5_issue_id", cmd_id, 3'd4); edge_();
      rst = 1'b1;
      #1;
      check("t5_iss_rst_valid", cmd_valid, 1'b0);
      check("t5_iss_rst_id", cmd_id, 3'd0);
      check("t5_iss_rst_av", action_valid, 7'h7f);
      edge_();
      rst       = 1'b0;
      cmd_ready = 1'b1;
      tick(1);
      action_pulse = 7'b100_0000;
      exp_q.push_back(6);
      mid(); check("t5_post_t0", cmd_valid, 1'b0); edge_();
      action_pulse = '0;
      mid(); check("t5_post_t1", cmd_valid, 1'b0); edge_();
      mid(); check("t5_post_valid", cmd_valid, 1'b1);
             check("t5_post_id", cmd_id, 3'd6); edge_();
      mid(); check("t5_post_t3", cmd_valid, 1'b0); edge_();

      // ---------------- arbitration order under re-pulsing ----------------
`ifdef INPUT_SCHED_RR_EN
      exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
      exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
`else
      exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0);
      exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(2);
`endif
      base_grants = grants;
      for (int c = 0; c < 3; c++) cnt[c] = 0;
      for (int cyc = 0; cyc < 30; cyc++) begin
         action_pulse = '0;
         for (int c = 0; c < 3; c++) begin
            if (action_valid[c] && cnt[c] < 2) begin
               action_pulse[c] = 1'b1;
               cnt[c]++;
            end
         end
         mid();
         edge_();
      end
      action_pulse = '0;
      check("t6_grant_count", grants - base_grants, 6);

      tick(2);
      check("sb_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/input_cmd_scheduler.md
# input_cmd_scheduler

Collects single-cycle action pulses from the per-button `DelayedAutoShiftFSM` instances and issues them one at a time to the game engine over a valid/ready command port. It drives each DAS instance's `action_valid` arm input, so a button cannot re-fire while its previous command is still pending. After a hard drop it enforces a lockout window in which all inputs are disarmed and stale moves are discarded.

## Interface
- `NUM_ACTIONS`, 7, number of action channels (0 left, 1 right, 2 rot CW, 3 rot CCW, 4 soft drop, 5 hard drop, 6 hold).
- `HARD_DROP_IDX`, 5, channel whose handshake starts lockout.
- `LOCKOUT_CYCLES`, 500_000, lockout length in clk cycles; 0 disables lockout.
- `clk`  in  1  system clock.
- `rst`  in  1  reset. One clock; reset is asynchronous and active-high.
- `action_pulse`  in  NUM_ACTIONS  one-cycle pulses, one bit per DAS instance `action_out`.
- `action_valid`  out  NUM_ACTIONS  arm signals, one bit per DAS instance `action_valid`.
- `game_active`  in  1  high while a piece is in play.
- `cmd_valid`  out  1  command offered to the engine.
- `cmd_id`  out  $clog2(NUM_ACTIONS)  channel index of the offered command.
- `cmd_ready`  in  1  engine accepts the command.
- `cmd_dropped`  out  1  one-cycle flag: a pulse arrived on a disarmed channel.

## Operation
- `pending[NUM_ACTIONS-1:0]` register: bit i is set at the edge after `action_pulse[i]` if `action_valid[i]` was high that cycle.
  - Pulse on a disarmed channel is ignored and `cmd_dropped` is high the next cycle.
  - If a set and a clear hit the same bit on the same edge, the set wins.
- `action_valid[i] = game_active && !pending[i] && state != LOCKOUT`. It is combinational from registers and `game_active`.
- FSM states are IDLE, ISSUE and LOCKOUT.
  - IDLE: if `pending != 0`, the arbiter picks a winner, `cmd_id` is registered, and the FSM goes to ISSUE.
  - ISSUE: `cmd_valid = 1`, and `cmd_id` is held stable until the handshake. On the edge where `cmd_valid && cmd_ready`, `pending[cmd_id]` clears.
    - If `cmd_id == HARD_DROP_IDX` and `LOCKOUT_CYCLES > 0`, go to LOCKOUT. Otherwise go to IDLE.
  - LOCKOUT: all `pending` bits clear on entry. The counter runs from 0 and the FSM returns to IDLE on the edge where the count equals `LOCKOUT_CYCLES-1`. Lockout is exactly `LOCKOUT_CYCLES` cycles.
- Arbitration default is fixed priority: lowest pending index wins.
- `game_active` low:
  - all pending bits clear every cycle;
  - an ISSUE in flight is never retracted and waits for `cmd_ready`;
  - LOCKOUT keeps counting.
- Lockout counter width is `$clog2(LOCKOUT_CYCLES+1)` and it never wraps.

## Timing
- Reset values: state IDLE, `pending` 0, `cmd_valid` 0, `cmd_id` 0, `cmd_dropped` 0, lockout count 0. During and after reset `action_valid` equals `{NUM_ACTIONS{game_active}}`.
- Latency: pulse in cycle t gives `pending` in t+1 (IDLE arbitrates) and `cmd_valid` in t+2.
- Throughput: at most one command per 2 cycles, because IDLE always spends one cycle.
- `action_valid[i]` falls in cycle t+1 after an accepted pulse in t. It rises the cycle after that channel's handshake edge, or after LOCKOUT exit.
- Asserting `rst` in any state forces reset values asynchronously. An in-flight command is lost and is not reissued.

## Configuration
- `INPUT_SCHED_RR_EN` defined: round-robin arbitration.
  - A pointer (reset 0) marks the highest-priority index. Search starts at the pointer and wraps modulo NUM_ACTIONS.
  - On each handshake the pointer becomes `cmd_id+1`, wrapping to 0 past NUM_ACTIONS-1.
- Not defined: fixed lowest-index priority and no pointer register.

## Test plan
- Reset, `game_active`=1; pulse ch2 at cycle 10, `cmd_ready` tied 1 -> `cmd_valid`=1 and `cmd_id`=2 in cycle 12 only; `action_valid[2]`=0 in cycles 11-12 and 1 from cycle 13.
- Pulses ch1 and ch4 same cycle, `cmd_ready`=0 for 5 cycles, then 1 -> `cmd_id`=1 held stable 6 cycles, then `cmd_id`=4 issued two cycles later.
- `LOCKOUT_CYCLES`=8: pulse ch0 and ch5 together, ready=1 -> ch0 issued, ch5 issued, then 8 cycles of `action_valid`=0; a pulse on ch3 in lockout gives `cmd_dropped`=1, no command.
- `game_active` falls while ch0 is in ISSUE and ch3 is pending -> ch0 completes on ready, `pending[3]` cleared, no further commands.
- `rst` asserted mid-LOCKOUT and mid-ISSUE -> all outputs at reset values immediately; first pulse after release issues with 2-cycle latency.
- `INPUT_SCHED_RR_EN`: ch0, ch1 and ch2 repeatedly re-pulsed as soon as re-armed, ready=1 -> grant order 0,1,2,0,1,2; without the macro the order is 0,1,0,1….
